// File: rtl/program_loader.sv
// Loads a byte stream into program RAM over the shared bus while the CPU is frozen,
// then restarts the CPU from address 0. All outputs are registered state decodes.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_abort,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              bus_en,
  output logic [DATA_W-1:0] bus_out,
  output logic              mem_MI,
  output logic              mem_WE,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_ADDR    = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
  localparam logic [2:0] S_RESTART = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ADDR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_addr;
  logic [DATA_W-1:0] r_byte;
  logic              r_err;

  logic              r_ld_ready;
  logic              r_cpu_hold;
  logic              r_cpu_rst;
  logic              r_bus_en;
  logic [DATA_W-1:0] r_bus_out;
  logic              r_mem_MI;
  logic              r_mem_WE;
  logic              r_busy;
  logic              r_done;

  logic [2:0]        w_state_next;
  logic [ADDR_W:0]   w_len_next;
  logic [ADDR_W:0]   w_addr_next;
  logic [DATA_W-1:0] w_byte_next;
  logic              w_err_next;
  logic [ADDR_W:0]   w_addr_inc;
  logic              w_abort;
  logic [DATA_W-1:0] w_bus_next;

  assign w_addr_inc = r_addr + ADDR_ONE;
  assign w_abort    = ld_abort && (r_state != S_IDLE) && (r_state != S_DONE);

  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_addr_next  = r_addr;
    w_byte_next  = r_byte;
    w_err_next   = r_err;
    case (r_state)
      S_IDLE: begin
        if (ld_start) begin
          w_len_next   = (ld_len > MAX_LEN) ? MAX_LEN : ld_len;
          w_addr_next  = '0;
          w_err_next   = 1'b0;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD:    w_state_next = (r_len == '0) ? S_RESTART : S_WAIT;
      S_WAIT: begin
        if (ld_valid) begin
          w_byte_next  = ld_data;
          w_state_next = S_ADDR;
        end
      end
      S_ADDR:    w_state_next = S_DATA;
      S_DATA: begin
        w_addr_next  = w_addr_inc;
        w_state_next = (w_addr_inc == r_len) ? S_RESTART : S_WAIT;
      end
      S_RESTART: w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    // Abort beats any same-cycle handshake: the offered byte is never latched.
    if (w_abort) begin
      w_state_next = S_IDLE;
      w_err_next   = 1'b1;
      w_addr_next  = r_addr;
      w_byte_next  = r_byte;
    end
  end

  always_comb begin
    w_bus_next = '0;
    if (w_state_next == S_ADDR) begin
      w_bus_next = DATA_W'(w_addr_next[ADDR_W-1:0]);
    end else if (w_state_next == S_DATA) begin
      w_bus_next = w_byte_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_addr  <= '0;
      r_byte  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_len   <= w_len_next;
      r_addr  <= w_addr_next;
      r_byte  <= w_byte_next;
      r_err   <= w_err_next;
    end
  end

  // Outputs are decoded from the next state so they are valid for the whole state cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_ready <= 1'b0;
      r_cpu_hold <= 1'b0;
      r_cpu_rst  <= 1'b0;
      r_bus_en   <= 1'b0;
      r_bus_out  <= '0;
      r_mem_MI   <= 1'b0;
      r_mem_WE   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ld_ready <= (w_state_next == S_WAIT);
      r_cpu_hold <= (w_state_next == S_HOLD) || (w_state_next == S_WAIT) ||
                    (w_state_next == S_ADDR) || (w_state_next == S_DATA) ||
                    (w_state_next == S_RESTART);
      r_cpu_rst  <= (w_state_next == S_RESTART);
      r_bus_en   <= (w_state_next == S_ADDR) || (w_state_next == S_DATA);
      r_bus_out  <= w_bus_next;
      r_mem_MI   <= (w_state_next == S_ADDR);
      r_mem_WE   <= (w_state_next == S_DATA);
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= (w_state_next == S_DONE);
    end
  end

  assign ld_ready = r_ld_ready;
  assign cpu_hold = r_cpu_hold;
  assign cpu_rst  = r_cpu_rst;
  assign bus_en   = r_bus_en;
  assign bus_out  = r_bus_out;
  assign mem_MI   = r_mem_MI;
  assign mem_WE   = r_mem_WE;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected (addr,data) writes,
// a negedge monitor with a small RAM model pops and compares each WE strobe.
module tb_program_loader;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ld_start = 1'b0;
  logic [ADDR_W:0]   ld_len = '0;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_ready;
  logic              ld_abort = 1'b0;
  logic              cpu_hold, cpu_rst, bus_en, mem_MI, mem_WE, busy, done, err;
  logic [DATA_W-1:0] bus_out;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_abort(ld_abort), .cpu_hold(cpu_hold), .cpu_rst(cpu_rst),
    .bus_en(bus_en), .bus_out(bus_out), .mem_MI(mem_MI), .mem_WE(mem_WE),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];
  int lat_bus = 0;
  int mon_e;
  logic [7:0] tb_mem [16];
  int wr_cnt [16];
  logic [7:0] img [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: RAM model plus bus invariants.
  always @(negedge clk) begin
    if (!rst) begin
      check("mi_we_exclusive", mem_MI & mem_WE, 0);
      if (!bus_en) check("bus_idle_zero", bus_out, 0);
      if (mem_MI) lat_bus = int'(bus_out);
      if (mem_WE) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", lat_bus, bus_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", lat_bus, mon_e >> 8);
          check("write_data", bus_out, mon_e & 255);
        end
        tb_mem[lat_bus[3:0]] = bus_out;
        wr_cnt[lat_bus[3:0]]++;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {ld_ready, cpu_hold, cpu_rst, bus_en, bus_out, mem_MI, mem_WE, busy, done, err}, 0);
  endtask

  task automatic run_load(input int len_in, input int nb, input int stall, input int abort_byte,
                          input bit poke_busy, input int exp_done, input string tag);
    int t0, rel, idx, stall_cnt, done_rel, rst_rel, hold_cnt;
    bit hold_at_done, pend, aborted, finished;
    logic [ADDR_W:0] len_v;
    idx = 0; stall_cnt = 0; done_rel = -1; rst_rel = -1; hold_cnt = 0;
    hold_at_done = 0; pend = 0; aborted = 0; finished = 0;
    len_v = len_in[ADDR_W:0];
    for (int a = 0; a < 16; a++) wr_cnt[a] = 0;
    @(negedge clk);
    ld_start = 1'b1;
    ld_len   = len_v;
    @(posedge clk);
    #1;
    t0 = cyc;
    ld_start = 1'b0;
    for (int n = 0; n < 400 && !finished; n++) begin
      @(negedge clk);
      rel = cyc - t0 + 1;
      ld_start = 1'b0;
      ld_abort = 1'b0;
      if (cpu_hold) hold_cnt++;
      if (cpu_rst) rst_rel = rel;
      if (done) begin
        done_rel = rel;
        hold_at_done = cpu_hold;
        finished = 1;
      end else if (aborted || !busy) begin
        finished = 1;
      end
      if (!finished) begin
        if (poke_busy && rel == 3) begin
          ld_start = 1'b1;
          ld_len   = 5'd9;
        end
        // Abort while the WE of the target byte is on the bus.
        if (abort_byte >= 0 && !aborted && mem_WE && idx == abort_byte + 1) begin
          ld_abort = 1'b1;
          aborted  = 1;
        end
        if (stall_cnt > 0) begin
          ld_valid = 1'b0;
          check({tag, "_stall_ready"}, ld_ready, 1);
          check({tag, "_stall_strobes"}, mem_MI | mem_WE, 0);
          stall_cnt--;
        end else if (idx < nb && !aborted) begin
          ld_valid = 1'b1;
          ld_data  = img[idx];
        end else begin
          ld_valid = 1'b0;
        end
        if (ld_valid && ld_ready && !ld_abort) begin
          exp_q.push_back((idx << 8) | int'(img[idx]));
          idx++;
          pend = (stall > 0);
        end else if (pend && mem_WE) begin
          pend = 0;
          stall_cnt = (idx < nb) ? stall : 0;
        end
      end
    end
    ld_valid = 1'b0; ld_start = 1'b0; ld_abort = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: load did not finish, required done or abort", tag);
    end
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
    if (abort_byte >= 0) begin
      check({tag, "_no_done"}, done_rel, -1);
      check({tag, "_no_cpu_rst"}, rst_rel, -1);
      check({tag, "_err"}, err, 1);
      check({tag, "_idle"}, {busy, bus_en, cpu_hold, mem_MI, mem_WE}, 0);
    end else begin
      check({tag, "_done_cycle"}, done_rel, exp_done);
      check({tag, "_rst_cycle"}, rst_rel, exp_done - 1);
      check({tag, "_hold_cycles"}, hold_cnt, exp_done - 1);
      check({tag, "_hold_at_done"}, hold_at_done, 0);
      check({tag, "_err_clear"}, err, 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) begin
      tb_mem[a] = 8'h00;
      wr_cnt[a] = 0;
      img[a]    = 8'h00;
    end
    // 1: asynchronous reset, outputs cleared without a clock edge
    #2 rst = 1'b1;
    #1 check_all_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // 2: three-byte load, valid held high
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0;
    run_load(3, 3, 0, -1, 0, 12, "load3");
    for (int a = 0; a < 3; a++) check("load3_mem", tb_mem[a], img[a]);

    // 3: stalling source, five idle WAIT cycles between bytes
    img[0] = 8'h5A; img[1] = 8'hC3; img[2] = 8'h07;
    run_load(3, 3, 5, -1, 0, 22, "stall");
    for (int a = 0; a < 3; a++) check("stall_mem", tb_mem[a], img[a]);

    // 4: full image, then an oversize length that must clamp to 16
    for (int a = 0; a < 16; a++) img[a] = 8'hA0 + 8'(a);
    run_load(16, 16, 0, -1, 0, 51, "full16");
    for (int a = 0; a < 16; a++) begin
      check("full16_mem", tb_mem[a], img[a]);
      check("full16_once", wr_cnt[a], 1);
    end
    for (int a = 0; a < 16; a++) img[a] = 8'h50 + 8'(a * 3);
    run_load(20, 16, 0, -1, 0, 51, "full20");
    for (int a = 0; a < 16; a++) begin
      check("full20_mem", tb_mem[a], img[a]);
      check("full20_once", wr_cnt[a], 1);
    end

    // 5: abort during DATA of byte 2 of 4
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    run_load(4, 4, 0, 2, 0, 0, "abort");
    check("abort_mem0", tb_mem[0], 8'h11);
    check("abort_mem1", tb_mem[1], 8'h22);
    check("abort_no_mem3", wr_cnt[3], 0);

    // 6: zero-length load, then ld_start while busy
    run_load(0, 0, 0, -1, 0, 3, "len0");
    img[0] = 8'h9C; img[1] = 8'h6D;
    run_load(2, 2, 0, -1, 1, 9, "busy_start");
    check("busy_start_mem0", tb_mem[0], 8'h9C);
    check("busy_start_mem1", tb_mem[1], 8'h6D);
    check("busy_start_no_mem2", wr_cnt[2], 0);

    // Async reset mid-load releases the bus immediately.
    @(negedge clk);
    ld_start = 1'b1;
    ld_len   = 5'd3;
    @(negedge clk);
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    begin
      int k;
      k = 0;
      while (!mem_MI && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("midload_reached_addr", mem_MI, 1);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("midload_reset_outputs");
    ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("after_midload_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
